// File: rtl/dds_wave_gen.sv
// Multi-mode DDS waveform source: phase accumulator with wrap-aligned tuning
// update, waveform shaper, saturating gain stage, offset-binary DAC output.
module dds_wave_gen #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned OUT_W   = 14,
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned AMP_W   = 8,
    parameter int unsigned DUTY_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync,
    input  logic [ACC_W-1:0]   freq,
    input  logic [PHASE_W-1:0] phase,
    input  logic               freq_ld,
    input  logic [1:0]         mode,
    input  logic [AMP_W-1:0]   amp,
    input  logic [DUTY_W-1:0]  duty,
    output logic [OUT_W-1:0]   dac_out,
    output logic               out_valid,
    output logic               wrap,
    output logic               upd_pend
);

    localparam int unsigned S_W   = OUT_W + 1;
    localparam int unsigned P_W   = S_W + AMP_W + 1;
    localparam int unsigned SH    = AMP_W - 1;
    localparam int unsigned PH_SH = ACC_W - PHASE_W;
    localparam int unsigned U_SH  = ACC_W - OUT_W;
    localparam int unsigned D_SH  = OUT_W - DUTY_W;

    localparam logic [OUT_W-1:0]        MID       = OUT_W'(2**(OUT_W-1));
    localparam logic signed [S_W-1:0]   MID_S     = S_W'(2**(OUT_W-1));
    localparam logic signed [S_W-1:0]   MID_M1_S  = S_W'(2**(OUT_W-1) - 1);
    localparam logic signed [S_W-1:0]   NEG_MID_S = -MID_S;
    localparam logic signed [P_W-1:0]   MID_P     = P_W'(2**(OUT_W-1));
    localparam logic signed [P_W-1:0]   MAX_P     = P_W'(2**OUT_W - 1);

    localparam logic [1:0] MODE_SAW_UP = 2'b00;
    localparam logic [1:0] MODE_SAW_DN = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    // Stage 0 state
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   freq_act_q, freq_act_d;
    logic [PHASE_W-1:0] phase_act_q, phase_act_d;
    logic [ACC_W-1:0]   freq_pend_q, freq_pend_d;
    logic [PHASE_W-1:0] phase_pend_q, phase_pend_d;
    logic               upd_pend_q, upd_pend_d;
    logic               wrap_q, wrap_d;

    // Pipeline state
    logic signed [S_W-1:0] s1_q, s1_d;
    logic                  valid1_q, valid1_d;
    logic signed [P_W-1:0] prod_q, prod_d;
    logic                  valid2_q, valid2_d;
    logic [OUT_W-1:0]      dac_out_q, dac_out_d;
    logic                  out_valid_q, out_valid_d;

    logic [ACC_W:0]        sum_c;
    logic                  apply_c;
    logic [ACC_W-1:0]      pw_c;
    logic [OUT_W-1:0]      u_c;
    logic [OUT_W-1:0]      tri_c;
    logic signed [P_W-1:0] y_c;
    logic signed [P_W-1:0] o_c;
    logic [OUT_W-1:0]      sat_c;

    assign sum_c = {1'b0, acc_q} + {1'b0, freq_act_q};

    // Accumulator, wrap pulse and shadowed tuning update
    always_comb begin
        acc_d        = acc_q;
        freq_act_d   = freq_act_q;
        phase_act_d  = phase_act_q;
        freq_pend_d  = freq_pend_q;
        phase_pend_d = phase_pend_q;
        upd_pend_d   = upd_pend_q;
        wrap_d       = sync | (en & sum_c[ACC_W]);
        apply_c      = wrap_d | ~en;

        if (sync) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_c[ACC_W-1:0];
        end

        if (freq_ld) begin
            freq_pend_d  = freq;
            phase_pend_d = phase;
        end

        // A load on an apply edge bypasses pending so active never lags a cycle
        if (apply_c) begin
            freq_act_d  = freq_ld ? freq  : freq_pend_q;
            phase_act_d = freq_ld ? phase : phase_pend_q;
            upd_pend_d  = 1'b0;
        end else if (freq_ld) begin
            upd_pend_d = 1'b1;
        end
    end

    // Stage 1: phase word and waveform shape
    always_comb begin
        pw_c     = acc_q + (ACC_W'(phase_act_q) << PH_SH);
        u_c      = OUT_W'(pw_c >> U_SH);
        tri_c    = u_c[OUT_W-1] ? ~{u_c[OUT_W-2:0], 1'b0} : {u_c[OUT_W-2:0], 1'b0};
        s1_d     = '0;
        valid1_d = en;
        case (mode)
            MODE_SAW_UP: s1_d = signed'({1'b0, u_c}) - MID_S;
            MODE_SAW_DN: s1_d = MID_M1_S - signed'({1'b0, u_c});
            MODE_TRI:    s1_d = signed'({1'b0, tri_c}) - MID_S;
            default:     s1_d = (u_c < (OUT_W'(duty) << D_SH)) ? MID_M1_S : NEG_MID_S;
        endcase
    end

    // Stage 2: full-width signed product with zero-extended gain
    always_comb begin
        prod_d   = P_W'(s1_q) * P_W'(signed'({1'b0, amp}));
        valid2_d = valid1_q;
    end

    // Stage 3: rescale, recentre on mid-scale and clamp to the DAC range
    always_comb begin
        y_c   = prod_q >>> SH;
        o_c   = y_c + MID_P;
        sat_c = o_c[OUT_W-1:0];
        if (o_c[P_W-1]) begin
            sat_c = '0;
        end else if (o_c > MAX_P) begin
            sat_c = '1;
        end
        dac_out_d   = valid2_q ? sat_c : MID;
        out_valid_d = valid2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            freq_act_q   <= '0;
            phase_act_q  <= '0;
            freq_pend_q  <= '0;
            phase_pend_q <= '0;
            upd_pend_q   <= 1'b0;
            wrap_q       <= 1'b0;
            s1_q         <= '0;
            valid1_q     <= 1'b0;
            prod_q       <= '0;
            valid2_q     <= 1'b0;
            dac_out_q    <= MID;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            freq_act_q   <= freq_act_d;
            phase_act_q  <= phase_act_d;
            freq_pend_q  <= freq_pend_d;
            phase_pend_q <= phase_pend_d;
            upd_pend_q   <= upd_pend_d;
            wrap_q       <= wrap_d;
            s1_q         <= s1_d;
            valid1_q     <= valid1_d;
            prod_q       <= prod_d;
            valid2_q     <= valid2_d;
            dac_out_q    <= dac_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign dac_out   = dac_out_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;
    assign upd_pend  = upd_pend_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: directed scenarios plus random stimulus, checked
// every cycle against a timeline reference model of the waveform source.
module tb_dds_wave_gen;

    localparam int     MID     = 8192;
    localparam int     OMAX    = 16383;
    localparam longint ACC_MOD = 64'sd16777216;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic        freq_ld = 1'b0;
    logic [23:0] freq = '0;
    logic [7:0]  phase = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  amp = '0;
    logic [7:0]  duty = '0;
    logic [13:0] dac_out;
    logic        out_valid;
    logic        wrap;
    logic        upd_pend;

    always #5 clk = ~clk;

    dds_wave_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .freq     (freq),
        .phase    (phase),
        .freq_ld  (freq_ld),
        .mode     (mode),
        .amp      (amp),
        .duty     (duty),
        .dac_out  (dac_out),
        .out_valid(out_valid),
        .wrap     (wrap),
        .upd_pend (upd_pend)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: tuning registers plus a short per-edge history
    longint m_acc, m_fa, m_pa, m_fp, m_pp;
    bit     m_pend, m_wrap;
    int     n = 0;
    int     base = 1;
    longint acc_h [8];
    longint pa_h  [8];
    bit     en_h  [8];
    int     mode_h[8];
    int     duty_h[8];
    int     amp_h [8];

    function automatic int shape(input int u, input int md, input int dt);
        case (md)
            0:       return u - MID;
            1:       return MID - 1 - u;
            2:       return ((u < MID) ? 2 * u : 32767 - 2 * u) - MID;
            default: return (u < dt * 64) ? MID - 1 : -MID;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_fa = 0; m_pa = 0; m_fp = 0; m_pp = 0;
        m_pend = 1'b0; m_wrap = 1'b0;
        base = n + 1;
    endtask

    task automatic model_edge();
        longint sum;
        bit     wr;
        bit     apply;
        sum   = m_acc + m_fa;
        wr    = sync || (en && sum >= ACC_MOD);
        apply = wr || !en;
        if (sync)    m_acc = 0;
        else if (en) m_acc = sum % ACC_MOD;
        if (freq_ld) begin
            m_fp = longint'(freq);
            m_pp = longint'(phase);
        end
        if (apply) begin
            m_fa = m_fp; m_pa = m_pp; m_pend = 1'b0;
        end else if (freq_ld) begin
            m_pend = 1'b1;
        end
        m_wrap = wr;
        n++;
        acc_h[n % 8]  = m_acc;
        pa_h[n % 8]   = m_pa;
        en_h[n % 8]   = en;
        mode_h[n % 8] = int'(mode);
        duty_h[n % 8] = int'(duty);
        amp_h[n % 8]  = int'(amp);
    endtask

    // Sample after edge n comes from acc after edge n-3, mode/duty/en at n-2, amp at n-1
    task automatic cycle();
        int     o;
        bit     v;
        longint a3, p3, pw;
        int     s, y;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        v = (n - 2 >= base) && en_h[(n - 2) % 8];
        o = MID;
        if (v) begin
            a3 = (n - 3 >= base) ? acc_h[(n - 3) % 8] : 0;
            p3 = (n - 3 >= base) ? pa_h[(n - 3) % 8]  : 0;
            pw = (a3 + p3 * 65536) % ACC_MOD;
            s  = shape(int'(pw / 1024), mode_h[(n - 2) % 8], duty_h[(n - 2) % 8]);
            y  = (s * amp_h[(n - 1) % 8]) >>> 7;
            o  = y + MID;
            if (o < 0)    o = 0;
            if (o > OMAX) o = OMAX;
        end
        check("dac_out", 32'(dac_out), 32'(o));
        check("out_valid", 32'(out_valid), 32'(v));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("upd_pend", 32'(upd_pend), 32'(m_pend));
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) cycle();
    endtask

    task automatic pulse_ld(input logic [23:0] f, input logic [7:0] p);
        freq = f; phase = p; freq_ld = 1'b1;
        cycle();
        freq_ld = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dac"}, 32'(dac_out), 32'(MID));
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_wrap"}, 32'(wrap), 32'd0);
        check({tag, "_upd"}, 32'(upd_pend), 32'd0);
    endtask

    task automatic wait_wrap(input string tag);
        int w;
        w = 0;
        while (wrap !== 1'b1 && w < 4000) begin
            cycle();
            w++;
        end
        check(tag, 32'(w < 4000), 32'd1);
    endtask

    initial begin
        // Reset held with en=1 and the clock running
        en = 1'b1; amp = 8'd128; mode = 2'b00; duty = 8'd0; freq = '0;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        rst_n = 1'b1;
        model_reset();
        run(10);

        // Saw up: load with en low so the new tuning applies at once
        en = 1'b0;
        pulse_ld(24'd16384, 8'd0);
        en = 1'b1;
        run(2100);

        // Triangle at half gain, then saw at near-double gain
        mode = 2'b10; amp = 8'd64;  run(1100);
        mode = 2'b00; amp = 8'd255; run(1100);

        // Square at quarter duty
        mode = 2'b11; amp = 8'd128; duty = 8'd64; run(1100);

        // Mid-period tuning update waits for wrap
        mode = 2'b00;
        wait_wrap("wrap_seen_a");
        run(500);
        pulse_ld(24'd32768, 8'd128);
        check("upd_pend_set", 32'(upd_pend), 32'd1);
        run(1100);

        // Sync restart mid-period
        run(200);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync_wrap", 32'(wrap), 32'd1);
        run(300);

        // Enable low: accumulator holds, output parks at mid-scale
        en = 1'b0;
        run(10);
        check("en_low_dac", 32'(dac_out), 32'(MID));
        check("en_low_valid", 32'(out_valid), 32'd0);
        en = 1'b1;
        run(200);

        // Random mode/gain/duty/tuning/sync/enable activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 49) == 0) amp  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) duty = 8'($urandom);
            if (en && $urandom_range(0, 199) == 0)      en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            sync    = ($urandom_range(0, 149) == 0);
            freq_ld = ($urandom_range(0, 39) == 0);
            if (freq_ld) begin
                freq  = 24'($urandom_range(4096, 1048576));
                phase = 8'($urandom);
            end
            cycle();
            sync = 1'b0; freq_ld = 1'b0;
        end

        // Asynchronous reset mid-operation with an update pending
        en = 1'b1; mode = 2'b00; amp = 8'd128;
        freq = 24'd16384; phase = '0;
        en = 1'b0; pulse_ld(24'd16384, 8'd0); en = 1'b1;
        run(20);
        pulse_ld(24'd65536, 8'd7);
        run(5);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        check_reset_vals("rst_async_hold");
        rst_n = 1'b1;
        model_reset();
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
